// File: rtl/bus_pkg.sv
// Shared definitions for the common-bus source select path: select codes,
// controller states and default widths.
package bus_pkg;

    localparam int BUS_DATA_W = 16;
    localparam int BUS_ADDR_W = 12;
    localparam int CNT_W      = 8;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_AR   = 3'd1;
    localparam logic [2:0] SEL_PC   = 3'd2;
    localparam logic [2:0] SEL_DR   = 3'd3;
    localparam logic [2:0] SEL_AC   = 3'd4;
    localparam logic [2:0] SEL_IR   = 3'd5;
    localparam logic [2:0] SEL_TR   = 3'd6;
    localparam logic [2:0] SEL_M    = 3'd7;

    localparam logic [6:0] OE_MEM = 7'b1000000;

    typedef enum logic {
        IDLE,
        MEM_WAIT
    } bus_state_e;

endpackage

// File: rtl/bus_sel_decode.sv
// Combinational 3-to-7 one-hot decode of the bus select code; code 0 enables nothing.
module bus_sel_decode
    import bus_pkg::*;
(
    input  logic [2:0] sel_i,
    output logic [6:0] oe_o
);

    always_comb begin
        oe_o = '0;
        case (sel_i)
            SEL_AR:  oe_o = 7'b0000001;
            SEL_PC:  oe_o = 7'b0000010;
            SEL_DR:  oe_o = 7'b0000100;
            SEL_AC:  oe_o = 7'b0001000;
            SEL_IR:  oe_o = 7'b0010000;
            SEL_TR:  oe_o = 7'b0100000;
            SEL_M:   oe_o = OE_MEM;
            default: oe_o = '0;
        endcase
    end

endmodule

// File: rtl/bus_source_decoder.sv
// Turns the bus select code into a one-hot source enable and a registered bus
// word; memory sources run a read request/ack handshake with a timeout.
module bus_source_decoder
    import bus_pkg::*;
#(
    parameter int DATA_W      = BUS_DATA_W,
    parameter int ADDR_W      = BUS_ADDR_W,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        sel,
    input  logic              sel_valid,
    input  logic [ADDR_W-1:0] ar_q,
    input  logic [ADDR_W-1:0] pc_q,
    input  logic [DATA_W-1:0] dr_q,
    input  logic [DATA_W-1:0] ac_q,
    input  logic [DATA_W-1:0] ir_q,
    input  logic [DATA_W-1:0] tr_q,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_rd,
    output logic [6:0]        src_oe,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_valid,
    output logic              busy,
    output logic              err
);

    localparam int              PAD_W     = DATA_W - ADDR_W;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    bus_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic [6:0]        src_oe_q, src_oe_d;
    logic              mem_rd_q, mem_rd_d;
    logic              bus_valid_q, bus_valid_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic [6:0]        dec_oe;
    logic [DATA_W-1:0] src_word;
    logic [CNT_W-1:0]  cnt_inc;

    bus_sel_decode u_dec (
        .sel_i (sel),
        .oe_o  (dec_oe)
    );

    // AR/PC are narrower than the bus and are zero-extended onto it.
    always_comb begin
        src_word = '0;
        case (sel)
            SEL_AR:  src_word = {{PAD_W{1'b0}}, ar_q};
            SEL_PC:  src_word = {{PAD_W{1'b0}}, pc_q};
            SEL_DR:  src_word = dr_q;
            SEL_AC:  src_word = ac_q;
            SEL_IR:  src_word = ir_q;
            SEL_TR:  src_word = tr_q;
            default: src_word = '0;
        endcase
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_out_d   = bus_out_q;
        src_oe_d    = '0;
        mem_rd_d    = 1'b0;
        bus_valid_d = 1'b0;
        busy_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    if (sel == SEL_NONE) begin
                        err_d = 1'b1;
                    end else if (sel == SEL_M) begin
                        src_oe_d = dec_oe;
                        mem_rd_d = 1'b1;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        state_d  = MEM_WAIT;
                    end else begin
                        src_oe_d    = dec_oe;
                        bus_out_d   = src_word;
                        bus_valid_d = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                // An ack on the timeout edge still completes the read.
                if (mem_ack) begin
                    bus_out_d   = mem_rdata;
                    bus_valid_d = 1'b1;
                    src_oe_d    = OE_MEM;
                    state_d     = IDLE;
                end else if (cnt_inc == TIMEOUT_C) begin
                    cnt_d   = cnt_inc;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d    = cnt_inc;
                    src_oe_d = OE_MEM;
                    mem_rd_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_out_q   <= '0;
            src_oe_q    <= '0;
            mem_rd_q    <= 1'b0;
            bus_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_out_q   <= bus_out_d;
            src_oe_q    <= src_oe_d;
            mem_rd_q    <= mem_rd_d;
            bus_valid_q <= bus_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign mem_rd    = mem_rd_q;
    assign src_oe    = src_oe_q;
    assign bus_out   = bus_out_q;
    assign bus_valid = bus_valid_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bus_source_decoder.sv
// Scoreboard bench for bus_source_decoder: every bus_valid/err event is matched
// against an expectation queued when the stimulus was driven.
module tb_bus_source_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  sel;
    logic        sel_valid;
    logic [11:0] ar_q, pc_q;
    logic [15:0] dr_q, ac_q, ir_q, tr_q;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        mem_rd;
    logic [6:0]  src_oe;
    logic [15:0] bus_out;
    logic        bus_valid;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        is_err;
        logic [15:0] data;
        logic [6:0]  oe;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    logic [15:0] last_bus;

    bus_source_decoder #(.DATA_W(16), .ADDR_W(12), .MEM_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .sel_valid (sel_valid),
        .ar_q      (ar_q),
        .pc_q      (pc_q),
        .dr_q      (dr_q),
        .ac_q      (ac_q),
        .ir_q      (ir_q),
        .tr_q      (tr_q),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_rd    (mem_rd),
        .src_oe    (src_oe),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_err, input logic [15:0] d, input logic [6:0] oe);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        e.oe     = oe;
        sb.push_back(e);
        if (!is_err) last_bus = d;
    endtask

    function automatic logic [15:0] src_model(input int s);
        case (s)
            1:       return {4'h0, ar_q};
            2:       return {4'h0, pc_q};
            3:       return dr_q;
            4:       return ac_q;
            5:       return ir_q;
            6:       return tr_q;
            default: return 16'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (bus_valid || err) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'({bus_valid, err}), 32'(0));
            end else begin
                m_e = sb.pop_front();
                chk("sb_kind", 32'({bus_valid, err}), m_e.is_err ? 32'(2'b01) : 32'(2'b10));
                chk("sb_data", 32'(bus_out), 32'(m_e.data));
                chk("sb_oe",   32'(src_oe),  32'(m_e.oe));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst_n = 1'b0; sel = 3'd7; sel_valid = 1'b1;
        ar_q = '0; pc_q = '0; dr_q = '0; ac_q = '0; ir_q = '0; tr_q = '0;
        mem_rdata = '0; mem_ack = 1'b0; last_bus = '0;

        // Reset held with a pending memory request
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_mem_rd", 32'(mem_rd), 32'(0));
            chk("rst_outs", 32'({src_oe, bus_out, bus_valid, busy, err}), 32'(0));
        end
        sel_valid = 1'b0; rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'({mem_rd, src_oe, bus_valid, busy, err}), 32'(0));

        // Back-to-back register sources
        ar_q = 12'hABC; sel = 3'd1; sel_valid = 1'b1;
        push(1'b0, 16'h0ABC, 7'b0000001);
        tick();
        ac_q = 16'h1234; sel = 3'd4;
        push(1'b0, 16'h1234, 7'b0001000);
        tick();
        chk("b2b_valid", 32'(bus_valid), 32'(1));
        for (int s = 1; s <= 6; s++) begin
            ar_q = 12'($urandom()); pc_q = 12'($urandom());
            dr_q = 16'($urandom()); ac_q = 16'($urandom());
            ir_q = 16'($urandom()); tr_q = 16'($urandom());
            sel = 3'(s);
            push(1'b0, src_model(s), 7'(7'b1 << (s - 1)));
            tick();
        end
        sel_valid = 1'b0;
        tick();
        chk("idle_no_valid", 32'({bus_valid, src_oe}), 32'(0));
        chk("idle_hold", 32'(bus_out), 32'(last_bus));

        // Memory read, ack three cycles after mem_rd rises
        sel = 3'd7; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        chk("mem_rd_rise", 32'({mem_rd, src_oe}), 32'({1'b1, 7'b1000000}));
        chk("mem_busy0", 32'(busy), 32'(1));
        tick(); chk("mem_busy1", 32'(busy), 32'(1));
        tick(); chk("mem_busy2", 32'(busy), 32'(1));
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        push(1'b0, 16'hBEEF, 7'b1000000);
        tick();
        mem_ack = 1'b0;
        chk("mem_done", 32'({mem_rd, busy}), 32'(0));
        tick();
        chk("mem_oe_clear", 32'({src_oe, bus_valid}), 32'(0));
        chk("mem_hold", 32'(bus_out), 32'(16'hBEEF));

        // Timeout with no ack
        sel = 3'd7; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        for (int i = 1; i < 15; i++) begin
            tick();
            chk("to_wait", 32'({err, busy, mem_rd}), 32'(3'b011));
        end
        push(1'b1, last_bus, 7'b0000000);
        tick();
        chk("to_err", 32'({err, busy, mem_rd}), 32'(3'b100));
        chk("to_bus_hold", 32'(bus_out), 32'(16'hBEEF));
        tick();
        chk("to_err_pulse", 32'(err), 32'(0));
        tr_q = 16'h7E57; sel = 3'd6; sel_valid = 1'b1;
        push(1'b0, 16'h7E57, 7'b0100000);
        tick();
        sel_valid = 1'b0;

        // Ack on the timeout edge wins
        sel = 3'd7; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        push(1'b0, 16'hCAFE, 7'b1000000);
        tick();
        mem_ack = 1'b0;
        chk("ack_wins_no_err", 32'({err, bus_valid}), 32'(2'b01));
        tick();

        // sel=0 request
        sel = 3'd0; sel_valid = 1'b1;
        push(1'b1, last_bus, 7'b0000000);
        tick();
        sel_valid = 1'b0;
        chk("sel0_no_valid", 32'(bus_valid), 32'(0));
        tick();

        // Register request during MEM_WAIT is ignored
        ir_q = 16'h5A5A;
        sel = 3'd7; sel_valid = 1'b1;
        tick();
        sel = 3'd5;
        tick();
        tick();
        chk("ign_no_valid", 32'(bus_valid), 32'(0));
        chk("ign_still_busy", 32'(busy), 32'(1));
        sel_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1111;
        push(1'b0, 16'h1111, 7'b1000000);
        tick();
        mem_ack = 1'b0;
        tick();
        chk("ign_ir_absent", 32'(bus_out), 32'(16'h1111));

        // Reset in the middle of a memory transfer
        sel = 3'd7; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_ctrl", 32'({mem_rd, busy, src_oe}), 32'(0));
        chk("midrst_bus", 32'(bus_out), 32'(0));
        rst_n = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        chk("midrst_late_ack", 32'(bus_valid), 32'(0));
        tick();
        mem_ack = 1'b0;
        chk("midrst_late_ack2", 32'(bus_valid), 32'(0));
        tick();

        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_source_decoder.md
# bus_source_decoder

Receiving end of the common-bus select code: takes the 3-bit source select produced by the bus select encoder and turns it into a one-hot source output enable and a registered 16-bit bus word. Sits between the control unit's select code and the bus consumers (AR, PC, DR, AC, IR, TR load paths and ALU). Register sources complete in one cycle. A memory source (select 7) runs a read request/acknowledge handshake with a timeout.

## Interface

- DATA_W, 16: bus and data-register width.
- ADDR_W, 12: AR/PC width; these are zero-extended onto the bus.
- MEM_TIMEOUT, 15: maximum cycles spent waiting for `mem_ack`; range 1..255.

Ports:

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- sel  in  3  source code: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 M.
- sel_valid  in  1  transfer request, sampled each edge.
- ar_q, pc_q  in  ADDR_W  register contents.
- dr_q, ac_q, ir_q, tr_q  in  DATA_W  register contents.
- mem_rdata  in  DATA_W  memory read data; valid when `mem_ack`=1.
- mem_ack  in  1  memory acknowledge.
- mem_rd  out  1  memory read request; level, held until ack or timeout.
- src_oe  out  7  one-hot source enable. Bit0 = AR … bit6 = M.
- bus_out  out  DATA_W  registered bus word.
- bus_valid  out  1  one-cycle pulse: `bus_out` is new.
- busy  out  1  memory transfer in progress; requests are ignored.
- err  out  1  one-cycle pulse: sel=0 request, or memory timeout.

## Operation

- States: IDLE, MEM_WAIT.
- IDLE, `sel_valid`=1, sel in 1..6:
  - At the next edge: `bus_out` gets the source value, with AR/PC zero-extended in the upper DATA_W-ADDR_W bits.
  - `src_oe` gets the one-hot code for that source, and `bus_valid`=1.
  - State stays IDLE, so back-to-back requests are accepted every cycle.
- IDLE, `sel_valid`=1, sel=7:
  - At the next edge: `mem_rd`=1, `busy`=1, `src_oe`=7'b1000000, timeout counter=0.
  - State goes to MEM_WAIT.
- IDLE, `sel_valid`=1, sel=0: `err`=1 for one cycle; `bus_out` unchanged; `src_oe`=0.
- IDLE, no request: `src_oe`=0 and `bus_valid`=0; `bus_out` holds.
- MEM_WAIT, each edge:
  - `mem_ack`=1: `bus_out`=`mem_rdata`, `bus_valid`=1, `mem_rd`=0, `busy`=0, go to IDLE. `src_oe` stays 7'b1000000 for that valid cycle, then clears.
  - Otherwise the counter increments. When it reaches MEM_TIMEOUT: `err`=1, `mem_rd`=0, `busy`=0, `src_oe`=0, go to IDLE, `bus_out` unchanged.
- Ack on the same edge as the timeout: ack wins, with no `err`.
- `sel_valid` during MEM_WAIT is ignored. It is not queued.
- `mem_ack` while in IDLE is ignored.
- Reset (`rst_n`=0 at an edge), including mid-MEM_WAIT: IDLE, and every output 0 (`mem_rd`, `src_oe`, `bus_out`, `bus_valid`, `busy`, `err`, counter).

## Timing

- Register source:
  - Request sampled at edge k.
  - `bus_out`, `src_oe` and `bus_valid` are valid in the cycle after edge k (latency 1).
  - Source data is the value sampled at edge k.
- Memory:
  - Request at edge k: `mem_rd` high from edge k.
  - Ack sampled at edge k+n (n≥1): `bus_valid` high in the cycle after edge k+n.
  - Fastest memory turnaround is 2 cycles from request to valid.
- Timeout: `err` pulses in the cycle after the edge at which the counter reaches MEM_TIMEOUT, i.e. MEM_TIMEOUT edges after request acceptance.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Shared package `bus_pkg` holds:
  - select-code constants SEL_NONE=0, SEL_AR=1, SEL_PC=2, SEL_DR=3, SEL_AC=4, SEL_IR=5, SEL_TR=6, SEL_M=7 (the same codes the encoder emits);
  - the state enum {IDLE, MEM_WAIT};
  - the DATA_W/ADDR_W defaults.
- One sub-module: `bus_sel_decode`, a combinational 3-to-7 one-hot decode (code 0 gives 0). It is reused by any consumer that needs the load enables.
- The FSM, counter and data registers live in the top level.

## Test plan

- Reset: hold `rst_n`=0 for 2 edges with `sel_valid`=1, sel=7 → all outputs 0, `mem_rd` never asserted.
- Register sources: ar_q=12'hABC with sel=1, then ac_q=16'h1234 with sel=4, on consecutive cycles:
  - → `bus_out`=16'h0ABC with `src_oe`=7'b0000001, then 16'h1234 with `src_oe`=7'b0001000;
  - → `bus_valid` high both cycles.
- Memory read: sel=7, then `mem_ack` 3 cycles after `mem_rd` rises with mem_rdata=16'hBEEF:
  - → `busy` high 3 cycles, `bus_out`=16'hBEEF, one `bus_valid` pulse, `mem_rd` low after the ack.
- Timeout: sel=7, `mem_ack` never asserted, MEM_TIMEOUT=15:
  - → `err` pulse exactly 15 edges after acceptance;
  - → `bus_out` unchanged, `mem_rd`=0, back in IDLE.
  - Repeat with ack on the 15th edge → `bus_valid`, no `err`.
- Illegal and ignored requests:
  - sel=0 request → `err` pulse, no `bus_valid`.
  - sel=5 request during MEM_WAIT → ignored; ir_q never appears on `bus_out`.
- Reset mid-transfer: assert `rst_n`=0 during MEM_WAIT → next cycle `mem_rd`=0, `busy`=0; a later `mem_ack` produces no `bus_valid`.
